serial_pattern_detector: RTL

SERIAL_PATTERN_DETECTOR -- requirements
Module: serial_pattern_detector

---
 rtl/sd_pkg.sv | 6 +
 rtl/serial_pattern_detector_shift_reg.sv | 16 +
 rtl/serial_pattern_detector.sv | 57 +++++
 3 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared FSM state type and default widths for the serial pattern detector
package sd_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/serial_pattern_detector_shift_reg.sv
// shift_reg: W-bit serial-in shift register (clk, rst_n async low, clr sync, sh_en shift, sin in at LSB, q contents)
module shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         sh_en,
  input  logic         sin,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (sh_en) q <= W'({q, sin});
endmodule

// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: detects pattern (MSB oldest) in din stream; ports clk, rst_n, din, en, pattern, clr_cnt -> match, match_count, sat, busy
module serial_pattern_detector
  import sd_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             en,
  input  logic [PAT_W-1:0] pattern,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             sat,
  output logic             busy
);
  localparam int FW = $clog2(PAT_W + 1);
  state_t           state, state_nx;
  logic [PAT_W-1:0] shreg, sh_nx, pat_q, pat_nx;
  logic [FW-1:0]    fill, fill_nx;
  logic             hit;
  shift_reg #(.W(PAT_W)) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~en),
    .sh_en (en),
    .sin   (din),
    .q     (shreg)
  );
  // Compare against the post-shift value; on the IDLE exit edge the pattern being latched is the reference.
  always_comb begin
    sh_nx    = PAT_W'({shreg, din});
    pat_nx   = (state == IDLE) ? pattern : pat_q;
    fill_nx  = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
    state_nx = !en ? IDLE : (fill_nx == FW'(PAT_W)) ? RUN : FILL;
    hit      = en && (fill_nx == FW'(PAT_W)) && (sh_nx == pat_nx);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fill        <= '0;
      pat_q       <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      fill        <= en ? fill_nx : '0;
      if (state == IDLE && en) pat_q <= pattern;
      match       <= hit;
      match_count <= clr_cnt ? '0 : (hit && !sat) ? match_count + 1'b1 : match_count;
    end
  assign sat  = &match_count;
  assign busy = state != IDLE;
endmodule
